// File: rtl/a1csah_pkg.sv
// -----------------------------------------------------------------------------
// a1csah_pkg
//   Shared definitions for the a1csah16 core and the multi-cycle wrapper:
//   slice width, FSM state encoding and a constant clog2 helper.
// -----------------------------------------------------------------------------
package a1csah_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions; returns at least 1 so that
  // derived counters are never zero width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/a1csah16.sv
// -----------------------------------------------------------------------------
// a1csah16
//   16-bit carry-select adder core. Low byte ripples from cin; the high byte is
//   precomputed for both carry values and selected by the low-byte carry.
//   Also reports the group generate/propagate of the 16-bit slice so that an
//   upstream controller can build the inter-slice carry.
// Ports
//   cin   in  1   carry into bit 0
//   a, b  in  16  operands
//   s     out 16  a+b+cin mod 2^16
//   gen   out 1   slice generates a carry regardless of cin
//   prop  out 1   slice propagates cin to its carry out
// -----------------------------------------------------------------------------
module a1csah16 (
  input  logic        cin,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        gen,
  output logic        prop
);

  logic [8:0] lo_sum;     // low byte with the real carry in
  logic [8:0] lo_gen_sum; // low byte with carry in forced to 0
  logic [8:0] hi_sum0;    // high byte assuming low-byte carry 0
  logic [8:0] hi_sum1;    // high byte assuming low-byte carry 1

  assign lo_sum     = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign lo_gen_sum = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  assign hi_sum0    = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi_sum1    = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign s = {(lo_sum[8] ? hi_sum1[7:0] : hi_sum0[7:0]), lo_sum[7:0]};

  assign prop = &(a ^ b);
  assign gen  = hi_sum0[8] | ((&(a[15:8] ^ b[15:8])) & lo_gen_sum[8]);

endmodule

// File: rtl/a1csah_mc_adder.sv
// -----------------------------------------------------------------------------
// a1csah_mc_adder
//   Multi-cycle WIDTH-bit adder built around one a1csah16 core. Operands are
//   latched on accept and fed to the core one 16-bit slice per cycle, low slice
//   first; the carry between slices lives in carry_q and is formed from the
//   core's gen/prop. The result is presented with a valid/ready handshake and
//   a new operand pair may be accepted in the same cycle the result leaves.
// Parameters
//   WIDTH      operand/sum width, multiple of 16 and >= 32
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin)
//   out_valid / out_ready result handshake (sum, cout)
//   grp_gen / grp_prop    word generate/propagate (A1CSAH_MC_GP_OUT_EN only)
// Configuration
//   A1CSAH_MC_GP_OUT_EN   adds the word generate/propagate accumulators/ports
// -----------------------------------------------------------------------------
module a1csah_mc_adder
  import a1csah_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef A1CSAH_MC_GP_OUT_EN
  ,
  output logic             grp_gen,
  output logic             grp_prop
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q;
  logic               alive_q;   // holds in_ready low until the first edge after reset
  logic               accept;

  logic [SLICE_W-1:0] core_a, core_b, core_s;
  logic               core_gen, core_prop;

  // ---------------------------------------------------------------------------
  // Core: slice selected by idx_q, carry chain closed through carry_q.
  // ---------------------------------------------------------------------------
  assign core_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign core_b = b_q[SLICE_W*idx_q +: SLICE_W];

  a1csah16 u_core (
    .cin  (carry_q),
    .a    (core_a),
    .b    (core_b),
    .s    (core_s),
    .gen  (core_gen),
    .prop (core_prop)
  );

  // ---------------------------------------------------------------------------
  // Handshake and FSM
  // ---------------------------------------------------------------------------
  assign in_ready  = alive_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        idx_q   <= '0;
        carry_q <= cin;
      end else if (state_q == RUN) begin
        sum_q[SLICE_W*idx_q +: SLICE_W] <= core_s;
        carry_q <= core_gen | (core_prop & carry_q);
        // Saturate at the last slice; the FSM leaves RUN on that same edge.
        if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: the operand registers are pure data, always overwritten on accept
  // before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

`ifdef A1CSAH_MC_GP_OUT_EN
  // Word generate/propagate, folded slice by slice exactly like the carry.
  logic gg_q, gp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gg_q <= 1'b0;
      gp_q <= 1'b0;
    end else if (accept) begin
      gg_q <= 1'b0;
      gp_q <= 1'b1;
    end else if (state_q == RUN) begin
      gg_q <= core_gen | (core_prop & gg_q);
      gp_q <= gp_q & core_prop;
    end
  end

  assign grp_gen  = gg_q;
  assign grp_prop = gp_q;
`endif

endmodule

// File: tb/tb_a1csah_mc_adder.sv
// -----------------------------------------------------------------------------
// tb_a1csah_mc_adder
//   Directed and randomised checks of the multi-cycle adder at WIDTH=64.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_a1csah_mc_adder;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef A1CSAH_MC_GP_OUT_EN
  logic             grp_gen;
  logic             grp_prop;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  a1csah_mc_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef A1CSAH_MC_GP_OUT_EN
    ,
    .grp_gen   (grp_gen),
    .grp_prop  (grp_prop)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair and hold it until it is accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                      input logic op_c, output bit ok);
    a = op_a; b = op_b; cin = op_c; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Edges until out_valid is seen, or -1 if it never appears.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 64'd0) begin failures++; $display("FAIL reset_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef A1CSAH_MC_GP_OUT_EN
    checks++; if ({grp_gen, grp_prop} !== 2'b00) begin failures++; $display("FAIL reset_gp: got %b%b want 00", grp_gen, grp_prop); end
`endif
    #2 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready: got %b want 0 before first edge", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_carry_ripple();
    bit ok; int n;
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ripple_accept: got %b want 1", ok); end
    wait_valid(n);
    checks++; if (n != 4) begin failures++; $display("FAIL ripple_latency: got %0d want 4", n); end
    checks++; if (sum !== 64'd0) begin failures++; $display("FAIL ripple_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ripple_cout: got %b want 1", cout); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ripple_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_mixed();
    bit ok; int n;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, ok);
    wait_valid(n);
    checks++; if (n != 4) begin failures++; $display("FAIL mixed_latency: got %0d want 4", n); end
    checks++; if ({cout, sum} !== {1'b1, 64'd0}) begin failures++; $display("FAIL mixed_sum: got %b/%h want 1/0", cout, sum); end
`ifdef A1CSAH_MC_GP_OUT_EN
    checks++; if ({grp_gen, grp_prop} !== 2'b01) begin failures++; $display("FAIL mixed_gp: got gen=%b prop=%b want 0/1", grp_gen, grp_prop); end
`endif
    step();
  endtask

  task automatic test_stall();
    bit ok; int n;
    out_ready = 1'b0;
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, ok);
    wait_valid(n);
    checks++; if (n != 4) begin failures++; $display("FAIL stall_latency: got %0d want 4", n); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b1, 64'd0}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%b c=%b s=%h want v=1 r=0 c=1 s=0",
                 i, out_valid, in_ready, cout, sum);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    step();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL stall_to_idle: got v=%b r=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic             vc [3];
    logic [WIDTH:0]   ve [3];
    int  idx_in, got, last_c;
    bit  acc;
    va[0] = 64'd1;                    vb[0] = 64'd2;                    vc[0] = 1'b0; ve[0] = {1'b0, 64'd3};
    va[1] = 64'hFFFF_FFFF_0000_0000;  vb[1] = 64'h0000_0001_0000_0000;  vc[1] = 1'b0; ve[1] = {1'b1, 64'd0};
    va[2] = 64'h1234_5678_9ABC_DEF0;  vb[2] = 64'h1111_1111_1111_1111;  vc[2] = 1'b1; ve[2] = {1'b0, 64'h2345_6789_ABCD_F002};
    out_ready = 1'b1;
    idx_in = 0; got = 0; last_c = 0;
    a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if ({cout, sum} !== ve[got]) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got %b/%h want %b/%h", got, cout, sum, ve[got][WIDTH], ve[got][WIDTH-1:0]);
        end
        if (got > 0) begin
          checks++;
          if (c - last_c != 5) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", got, c - last_c); end
        end
        last_c = c;
        got++;
      end
      step();
      if (acc) begin
        idx_in++;
        if (idx_in < 3) begin
          a = va[idx_in]; b = vb[idx_in]; cin = vc[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", got); end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit ok; int n;
    send(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, ok);
    in_valid = 1'b1;  // must be ignored while running
    step(); step();   // now processing slice 2
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL run_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b0, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL midrun_reset: got v=%b r=%b c=%b s=%h want all 0", out_valid, in_ready, cout, sum);
    end
    step(); step();
    #2 rst_n = 1'b1;
    step();
    send(64'd1, 64'd1, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL after_reset_accept: got %b want 1", ok); end
    wait_valid(n);
    checks++; if ({cout, sum} !== {1'b0, 64'd2}) begin failures++; $display("FAIL after_reset_sum: got %b/%h want 0/2", cout, sum); end
    step();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, held_s;
    logic             rc, held_c, last_ready;
    logic [WIDTH:0]   exp;
    bit               ok, seen, done;
    for (int t = 0; t < 3000; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      out_ready = 1'b0;
      send(ra, rb, rc, ok);
      seen = 1'b0; done = 1'b0; last_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
        step();
        if (seen && last_ready) begin
          done = 1'b1;
          break;
        end
        if (out_valid) begin
          checks++;
          if (!seen) begin
            if ({cout, sum} !== exp) begin
              failures++;
              $display("FAIL rand_result[%0d]: %h+%h+%b got %b/%h want %b/%h",
                       t, ra, rb, rc, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
            end
            held_s = sum; held_c = cout; seen = 1'b1;
          end else if ({cout, sum} !== {held_c, held_s}) begin
            failures++;
            $display("FAIL rand_hold[%0d]: got %b/%h want %b/%h", t, cout, sum, held_c, held_s);
          end
          last_ready = ($urandom_range(0, 3) != 0);
          out_ready  = last_ready;
        end
      end
      if (!(ok && done)) begin
        checks++; failures++;
        $display("FAIL rand_timeout[%0d]: accepted=%b completed=%b want 1/1", t, ok, done);
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_mixed();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
